// File: rtl/freq_report_tx.sv
// rtl/freq_report_tx.sv - serialises the NCO phase increment as "F=<16 hex>\r\n" to the UART
// Snapshot is frozen per line; triggers arriving mid-line coalesce into one follow-up report.
module freq_report_tx #(
  parameter bit         AUTO_REPORT = 1'b1,
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [7:0] PREFIX_CHAR = 8'h46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PLL_inc,
  input  logic        report_req,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        report_busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic [15:0] TO_LOAD = 16'(ACK_TIMEOUT);

  logic [1:0]  state;
  logic [4:0]  idx;
  logic [63:0] snapshot;
  logic [63:0] prev_inc;
  logic        init;
  logic        pending;
  logic [15:0] cnt;

  logic        change;
  logic        trig;
  logic        line_step;
  logic [63:0] shifted;
  logic [7:0]  cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    change    = (PLL_inc != prev_inc) && !init;
    trig      = report_req | (AUTO_REPORT && change);
    // A missing busy acknowledge is treated exactly like the end of the byte.
    line_step = !tx_busy && ((state == WAIT_LO) || (state == WAIT_HI && cnt == 16'd0));
    shifted   = snapshot >> {(5'd17 - idx), 2'b00};
    case (idx)
      5'd0:    cur_byte = PREFIX_CHAR;
      5'd1:    cur_byte = 8'h3D;
      5'd18:   cur_byte = 8'h0D;
      5'd19:   cur_byte = 8'h0A;
      default: cur_byte = hex_char(shifted[3:0]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      report_busy <= 1'b0;
      pending     <= 1'b0;
      idx         <= 5'd0;
      state       <= IDLE;
      snapshot    <= 64'd0;
      prev_inc    <= 64'd0;
      init        <= 1'b1;
      cnt         <= 16'd0;
    end else begin
      prev_inc <= PLL_inc;
      init     <= 1'b0;
      tx_start <= 1'b0;
      if (trig && state != IDLE)
        pending <= 1'b1;
      if (line_step) begin
        if (idx == 5'd19) begin
          report_busy <= 1'b0;
          state       <= IDLE;
        end else begin
          idx   <= idx + 5'd1;
          state <= SEND;
        end
      end else begin
        case (state)
          IDLE: begin
            if (trig || pending) begin
              snapshot    <= PLL_inc;
              idx         <= 5'd0;
              report_busy <= 1'b1;
              pending     <= 1'b0;
              state       <= SEND;
            end
          end
          SEND: begin
            if (!tx_busy) begin
              tx_data  <= cur_byte;
              tx_start <= 1'b1;
              cnt      <= TO_LOAD;
              state    <= WAIT_HI;
            end
          end
          WAIT_HI: begin
            if (tx_busy)
              state <= WAIT_LO;
            else
              cnt <= cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_report_tx.sv
// tb/tb_freq_report_tx.sv - self-checking bench for freq_report_tx
// Line-level model: every accepted trigger queues the 20-byte ASCII line of the value it captures.
module tb_freq_report_tx;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pll = 64'd0;
  logic        req = 1'b0;
  logic        force_busy = 1'b0;
  logic        uart_b = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_start, report_busy, tx_start0, report_busy0;

  assign tx_busy = force_busy | uart_b;

  always #5 clk = ~clk;

  freq_report_tx #(.AUTO_REPORT(1'b1), .ACK_TIMEOUT(TO), .PREFIX_CHAR(8'h46)) dut (
    .clk(clk), .rst(rst), .PLL_inc(pll), .report_req(req), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .report_busy(report_busy));

  freq_report_tx #(.AUTO_REPORT(1'b0), .ACK_TIMEOUT(TO), .PREFIX_CHAR(8'h46)) dut0 (
    .clk(clk), .rst(rst), .PLL_inc(pll), .report_req(1'b0), .tx_busy(1'b0),
    .tx_data(tx_data0), .tx_start(tx_start0), .report_busy(report_busy0));

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int uart_len = 10, ucnt = 0;
  int line_cnt = 0, n_start0 = 0;
  logic [7:0] expq[$];
  logic [7:0] cap[$];
  int scyc[$];
  bit m_busy = 0, m_pend = 0, m_init = 1, prev_start = 0;
  logic [63:0] m_prev = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push_line(input logic [63:0] v);
    string h;
    h = $sformatf("%016h", v);
    h = h.toupper();
    expq.push_back(8'h46);
    expq.push_back(8'h3D);
    for (int i = 0; i < 16; i++) expq.push_back(h.getc(i));
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start0) n_start0++;
    if (rst) begin
      expq.delete();
      m_busy = 0; m_pend = 0; m_init = 1; m_prev = 64'd0;
      line_cnt = 0; prev_start = 0;
    end else begin
      if (tx_start) begin
        chk("start_while_busy", {63'd0, tx_busy}, 64'd0);
        chk("start_back_to_back", {63'd0, prev_start}, 64'd0);
        if (expq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_byte: got %02h with no byte required", tx_data);
        end else begin
          chk("tx_data", {56'd0, tx_data}, {56'd0, expq.pop_front()});
        end
        cap.push_back(tx_data);
        scyc.push_back(cyc);
        line_cnt++;
        if (line_cnt == 20) begin
          line_cnt = 0;
          if (m_pend) begin
            m_pend = 0;
            push_line(pll);
          end else begin
            m_busy = 0;
          end
        end
      end
      prev_start = tx_start;
      if (req || (pll !== m_prev && !m_init)) begin
        if (m_busy) m_pend = 1;
        else begin
          m_busy = 1;
          push_line(pll);
        end
      end
      m_prev = pll;
      m_init = 0;
    end
    if (tx_start && uart_len > 0) begin
      uart_b = 1'b1; ucnt = uart_len;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) uart_b = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic clear_cap();
    cap.delete();
    scyc.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (cap.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got %0d bytes required %0d", nm, cap.size(), n);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((report_busy || tx_busy) && k < 2000) begin
      tick(1);
      k++;
    end
    chk({nm, "_idle"}, {63'd0, report_busy}, 64'd0);
    chk({nm, "_drained"}, expq.size(), 64'd0);
  endtask

  task automatic check_line(input string nm, input int base, input string lit);
    string s = "";
    n_cmp++;
    if (cap.size() < base + 20) begin
      n_fail++;
      $display("FAIL %s: got %0d bytes required %0d", nm, cap.size(), base + 20);
      return;
    end
    for (int i = 0; i < 18; i++) s = $sformatf("%s%c", s, cap[base + i]);
    if (s != lit) begin
      n_fail++;
      $display("FAIL %s: got %s required %s", nm, s, lit);
    end
    chk({nm, "_cr"}, {56'd0, cap[base + 18]}, 64'h0D);
    chk({nm, "_lf"}, {56'd0, cap[base + 19]}, 64'h0A);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s, k;
    pll = 64'h01B1B1B1B1B1B1B1;
    rst = 1'b1;
    tick(3);
    chk("reset_tx_data", {56'd0, tx_data}, 64'd0);
    chk("reset_tx_start", {63'd0, tx_start}, 64'd0);
    chk("reset_report_busy", {63'd0, report_busy}, 64'd0);
    rst = 1'b0;
    tick(20);
    chk("no_report_after_reset", cap.size(), 64'd0);
    chk("idle_after_reset", {63'd0, report_busy}, 64'd0);

    // basic query with a 10-cycle UART
    clear_cap();
    c0 = cyc;
    pulse_req();
    wait_bytes(20, 600, "basic");
    check_line("basic_line", 0, "F=01B1B1B1B1B1B1B1");
    if (scyc.size() >= 20) begin
      chk("basic_latency", scyc[0] - c0, 64'd2);
      s = scyc[19];
      while (cyc < s + 10) tick(1);
      chk("busy_held_during_lf", {63'd0, report_busy}, 64'd1);
      tick(1);
      chk("busy_falls_after_lf", {63'd0, report_busy}, 64'd0);
    end
    wait_idle("basic");
    chk("basic_count", cap.size(), 64'd20);

    // hex digit edges; change and query in the same cycle make one trigger
    clear_cap();
    pll = 64'hFEDCBA9876543210;
    pulse_req();
    wait_bytes(20, 600, "hex");
    check_line("hex_line", 0, "F=FEDCBA9876543210");
    if (cap.size() >= 20) begin
      chk("hex_digit_a", {56'd0, cap[7]}, 64'h41);
      chk("hex_digit_9", {56'd0, cap[8]}, 64'h39);
    end
    wait_idle("hex");
    chk("hex_count", cap.size(), 64'd20);

    // auto report, mid-line change and two queries coalesce into one extra line
    clear_cap();
    pll = 64'h0104376A9DD10437;
    wait_bytes(5, 600, "auto_start");
    pll = 64'h019C0268CF359C02;
    tick(3);
    pulse_req();
    tick(20);
    pulse_req();
    wait_bytes(40, 2000, "auto");
    check_line("auto_line_old", 0, "F=0104376A9DD10437");
    check_line("auto_line_new", 20, "F=019C0268CF359C02");
    wait_idle("auto");
    tick(200);
    chk("auto_count", cap.size(), 64'd40);

    // stall then ack timeout
    clear_cap();
    force_busy = 1'b1;
    pulse_req();
    tick(50);
    chk("stall_no_start", cap.size(), 64'd0);
    uart_len = 0;
    force_busy = 1'b0;
    wait_bytes(20, 1500, "timeout");
    if (scyc.size() >= 20) begin
      chk("timeout_gap_first", scyc[1] - scyc[0], TO + 2);
      chk("timeout_gap_last", scyc[19] - scyc[18], TO + 2);
    end
    check_line("timeout_line", 0, "F=019C0268CF359C02");
    wait_idle("timeout");
    uart_len = 10;
    tick(5);

    // reset in the middle of a line
    clear_cap();
    pulse_req();
    k = 0;
    while (cap.size() < 6 && k < 600) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("abort_reached_idx5", cap.size(), 64'd6);
    rst = 1'b1;
    #1;
    chk("abort_tx_start", {63'd0, tx_start}, 64'd0);
    chk("abort_report_busy", {63'd0, report_busy}, 64'd0);
    chk("abort_tx_data", {56'd0, tx_data}, 64'd0);
    tick(3);
    rst = 1'b0;
    tick(30);
    chk("abort_no_resume", cap.size(), 64'd6);
    clear_cap();
    pulse_req();
    wait_bytes(20, 600, "post_reset");
    check_line("post_reset_line", 0, "F=019C0268CF359C02");
    wait_idle("post_reset");
    chk("post_reset_count", cap.size(), 64'd20);

    // AUTO_REPORT=0 instance saw every PLL_inc change above without a query
    chk("auto0_window", {63'd0, cyc >= 1000}, 64'd1);
    chk("auto0_no_start", n_start0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_report_tx.md
Name: freq_report_tx

Overview:
- Reports the active NCO phase increment back to the host over the UART transmit byte interface, in the opposite direction to the key-to-increment selector.
- Snapshots the 64-bit PLL_inc word and serialises it as the ASCII line "F=" + 16 uppercase hex digits + CR LF (20 bytes) to the UART transmitter.
- Triggered by an explicit host query pulse or, optionally, automatically whenever PLL_inc changes.

Parameters:
- AUTO_REPORT, 1, 1 = a change of PLL_inc triggers a report; 0 = only report_req triggers.
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before assuming the byte was accepted (minimum 2).
- PREFIX_CHAR, 8'h46, first byte of each line ('F').

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- PLL_inc  input  64  current phase increment from the frequency selector
- report_req  input  1  single-cycle query pulse, e.g. decoded '?' from the UART receiver
- tx_busy  input  1  UART transmitter busy; high while a byte is shifting out
- tx_data  output  8  byte presented to the UART transmitter
- tx_start  output  1  one-cycle strobe; tx_data is valid in the same cycle
- report_busy  output  1  high from trigger acceptance to the end of the LF byte

Behaviour:
- Clocking and reset:
  - One clock. Asynchronous active-high rst.
  - Reset values: tx_data=0, tx_start=0, report_busy=0, pending=0, byte index=0, state=IDLE, snapshot=0, prev_inc=0, init flag=1.
- Change detection:
  - prev_inc is registered from PLL_inc every cycle.
  - change = (PLL_inc != prev_inc) && !init.
  - init clears on the first clock after reset, so the capture after reset does not trigger a report.
- Trigger: trig = report_req | (AUTO_REPORT && change).
- State machine: IDLE, SEND, WAIT_HI, WAIT_LO.
  - IDLE: on trig or pending:
    - snapshot <= PLL_inc; idx <= 0.
    - report_busy <= 1; pending <= 0.
    - go to SEND.
  - SEND: when tx_busy==0:
    - tx_data <= byte[idx]; tx_start <= 1 for exactly one cycle.
    - Load the timeout counter with ACK_TIMEOUT; go to WAIT_HI.
    - While tx_busy==1, stay in SEND with tx_start held at 0.
  - WAIT_HI:
    - On tx_busy==1, go to WAIT_LO.
    - Otherwise decrement the counter; at 0, treat the byte as accepted and take the WAIT_LO exit directly.
  - WAIT_LO: on tx_busy==0:
    - If idx==19: report_busy <= 0, go to IDLE.
    - Otherwise idx <= idx+1, go to SEND.
- Byte map:
  - idx0 = PREFIX_CHAR.
  - idx1 = 8'h3D ('=').
  - idx2..17 = hex digit of snapshot[63-4*(idx-2) -: 4], most significant nibble first.
  - idx18 = 8'h0D (CR); idx19 = 8'h0A (LF).
- Hex encoding: nibble n<10 gives 8'h30+n; n>=10 gives 8'h37+n. Uppercase only; leading zeros are always sent.
- Latency with tx_busy low: report_req high in cycle 0 gives tx_start=1 with tx_data=8'h46 in cycle 2.
- The snapshot is frozen for the whole line. A PLL_inc change mid-line does not corrupt the line in flight.
- Triggers while report_busy=1 set pending. Any number of them coalesce into exactly one further report, which starts from IDLE after the LF byte with a fresh snapshot.
- A trigger in the same cycle as the LF completion also sets pending, and is not lost.
- rst asserted mid-line aborts immediately:
  - All outputs return to reset values and the partial line is not resumed.
  - The next report restarts at idx0.
- tx_start is never asserted in two consecutive cycles and never while tx_busy==1.

Test Plan:
- Basic query: PLL_inc=64'h01B1B1B1B1B1B1B1, one report_req pulse, UART model busy 10 cycles per byte -> exactly 20 strobes, bytes "F=01B1B1B1B1B1B1B1\r\n". report_busy falls after the LF busy drops.
- Hex edges: PLL_inc=64'hFEDCBA9876543210, query -> digits "FEDCBA9876543210". The nibble-A byte is 8'h41 and the nibble-9 byte is 8'h39.
- Auto-report and coalescing: AUTO_REPORT=1; switch PLL_inc from 64'h104376A9DD10437 to 64'h19c0268cf359c02 mid-line, then pulse report_req twice.
  - The first line carries the old value.
  - Exactly one extra line follows with "F=019C0268CF359C02".
  - No report is generated after the reset-release capture.
- Stall and timeout: hold tx_busy=1 for 50 cycles before a strobe -> no tx_start during the hold. Then, with a UART model that never raises tx_busy, the next byte strobes ACK_TIMEOUT+2 cycles after the previous one.
- Reset mid-line: assert rst after byte idx5 -> tx_start=0 and report_busy=0 immediately (asynchronously). A post-reset query sends a complete line beginning 8'h46.
- AUTO_REPORT=0: PLL_inc changes with no report_req -> zero tx_start pulses over 1000 cycles.
